regfile_mp: RTL and testbench

Parametrised multi-port register file for the RV32IM pipeline, the successor to the single-write, dual-read integer register file. It provides NUM_RD registered read ports and NUM_WR write ports with fixed write priority. It includes optional write-to-read bypass and a per-register pending scoreboard, so decode can detect RAW hazards against in-flight destinations. It sits between the decode stage (read and issue) and the writeback stage (writes).

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_scoreboard.sv | 37 +++
 rtl/regfile_mp.sv | 84 ++++++++
 tb/tb_regfile_mp.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants, types and the address-width helper for the integer register file.
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int DEPTH_DEF = 32;

  function automatic int addr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  typedef logic [$clog2(DEPTH_DEF)-1:0] reg_addr_t;
  typedef logic [XLEN_DEF-1:0]          reg_word_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits: issue sets, effective write clears, set beats clear.
// Lookups return the post-update value so decode sees same-cycle issues.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int DEPTH    = DEPTH_DEF,
  parameter  int NUM_RD   = 2,
  parameter  int ZERO_REG = 1,
  localparam int AW       = addr_w(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 iss_en_i,
  input  logic [AW-1:0]        iss_addr_i,
  input  logic [DEPTH-1:0]     clr_mask_i,
  input  logic [NUM_RD*AW-1:0] lk_addr_i,
  output logic [NUM_RD-1:0]    lk_pend_o
);

  logic [DEPTH-1:0] pend_q, pend_d;

  always_comb begin
    pend_d = pend_q & ~clr_mask_i;
    if (iss_en_i) pend_d[iss_addr_i] = 1'b1;
    if (ZERO_REG != 0) pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) pend_q <= '0;
    else     pend_q <= pend_d;
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_lk
    assign lk_pend_o[i] = pend_d[lk_addr_i[i*AW +: AW]];
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with registered reads and a pending scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writes into the read capture.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int XLEN     = XLEN_DEF,
  parameter  int DEPTH    = DEPTH_DEF,
  parameter  int NUM_RD   = 2,
  parameter  int NUM_WR   = 1,
  parameter  int ZERO_REG = 1,
  localparam int AW       = addr_w(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_WR-1:0]      wr_en_i,
  input  logic [NUM_WR*AW-1:0]   wr_addr_i,
  input  logic [NUM_WR*XLEN-1:0] wr_data_i,
  input  logic [NUM_RD*AW-1:0]   rd_addr_i,
  output logic [NUM_RD*XLEN-1:0] rd_data_o,
  output logic [NUM_RD-1:0]      rd_pending_o,
  input  logic                   iss_en_i,
  input  logic [AW-1:0]          iss_addr_i
);

  logic [XLEN-1:0]        mem_q [DEPTH];
  logic [XLEN-1:0]        mem_d [DEPTH];
  logic [DEPTH-1:0]       wr_hit;
  logic [NUM_RD*XLEN-1:0] rd_data_d, rd_data_q;
  logic [NUM_RD-1:0]      rd_pend_d, rd_pend_q;

  // Ascending port order: a later (higher-indexed) port overwrites earlier ones.
  always_comb begin
    mem_d  = mem_q;
    wr_hit = '0;
    for (int p = 0; p < NUM_WR; p++) begin
      if (wr_en_i[p] && !(ZERO_REG != 0 && wr_addr_i[p*AW +: AW] == '0)) begin
        mem_d[wr_addr_i[p*AW +: AW]]  = wr_data_i[p*XLEN +: XLEN];
        wr_hit[wr_addr_i[p*AW +: AW]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) mem_q <= '{default: '0};
    else     mem_q <= mem_d;
  end

  // Register 0 is never written when hardwired, so plain array reads return 0.
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
`ifdef REGFILE_BYPASS_EN
    assign rd_data_d[i*XLEN +: XLEN] = mem_d[rd_addr_i[i*AW +: AW]];
`else
    assign rd_data_d[i*XLEN +: XLEN] = mem_q[rd_addr_i[i*AW +: AW]];
`endif
  end

  regfile_scoreboard #(
    .DEPTH    (DEPTH),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .iss_en_i   (iss_en_i),
    .iss_addr_i (iss_addr_i),
    .clr_mask_i (wr_hit),
    .lk_addr_i  (rd_addr_i),
    .lk_pend_o  (rd_pend_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
      rd_pend_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
      rd_pend_q <= rd_pend_d;
    end
  end

  assign rd_data_o    = rd_data_q;
  assign rd_pending_o = rd_pend_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: directed cases then random traffic against an array model.
module tb_regfile_mp;

  localparam int XLEN = 32;
  localparam int DEPTH = 32;
  localparam int AW = 5;
  localparam int NUM_RD = 2;
  localparam int NUM_WR = 2;
  localparam int ZERO_REG = 1;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NUM_WR-1:0]      wr_en;
  logic [NUM_WR*AW-1:0]   wr_addr;
  logic [NUM_WR*XLEN-1:0] wr_data;
  logic [NUM_RD*AW-1:0]   rd_addr;
  logic [NUM_RD*XLEN-1:0] rd_data;
  logic [NUM_RD-1:0]      rd_pending;
  logic                   iss_en;
  logic [AW-1:0]          iss_addr;

  always #5 clk = ~clk;

  regfile_mp #(
    .XLEN(XLEN), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .ZERO_REG(ZERO_REG)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en_i      (wr_en),
    .wr_addr_i    (wr_addr),
    .wr_data_i    (wr_data),
    .rd_addr_i    (rd_addr),
    .rd_data_o    (rd_data),
    .rd_pending_o (rd_pending),
    .iss_en_i     (iss_en),
    .iss_addr_i   (iss_addr)
  );

  typedef struct packed {
    logic [NUM_RD*XLEN-1:0] data;
    logic [NUM_RD-1:0]      pend;
  } exp_t;

  exp_t  q_exp [$];
  string q_name [$];
  int    vectors = 0;
  int    miscompares = 0;

  // Reference state
  logic [XLEN-1:0] m_reg  [DEPTH];
  bit              m_pend [DEPTH];

  function automatic logic [XLEN-1:0] win_val(input logic [NUM_WR-1:0] we,
                                              input logic [AW-1:0] wa [NUM_WR],
                                              input logic [XLEN-1:0] wd [NUM_WR],
                                              input logic [AW-1:0] a);
    logic [XLEN-1:0] v;
    v = m_reg[a];
    for (int p = NUM_WR - 1; p >= 0; p--) begin
      if (we[p] && wa[p] == a) begin
        v = wd[p];
        break;
      end
    end
    if (ZERO_REG != 0 && a == 0) v = '0;
    return v;
  endfunction

  task automatic cyc(input string nm, input bit r, input logic [1:0] we,
                     input logic [AW-1:0] wa0, input logic [XLEN-1:0] wd0,
                     input logic [AW-1:0] wa1, input logic [XLEN-1:0] wd1,
                     input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
                     input bit ie, input logic [AW-1:0] ia);
    logic [AW-1:0]   wa [NUM_WR];
    logic [XLEN-1:0] wd [NUM_WR];
    logic [AW-1:0]   ra [NUM_RD];
    logic [XLEN-1:0] nxt [DEPTH];
    exp_t e;
    @(negedge clk);
    rst = r; wr_en = we; wr_addr = {wa1, wa0}; wr_data = {wd1, wd0};
    rd_addr = {ra1, ra0}; iss_en = ie; iss_addr = ia;
    wa[0] = wa0; wa[1] = wa1; wd[0] = wd0; wd[1] = wd1; ra[0] = ra0; ra[1] = ra1;
    if (r) begin
      for (int a = 0; a < DEPTH; a++) begin m_reg[a] = '0; m_pend[a] = 0; end
      e = '0;
    end else begin
      for (int a = 0; a < DEPTH; a++) nxt[a] = win_val(we, wa, wd, AW'(a));
      for (int i = 0; i < NUM_RD; i++)
        e.data[i*XLEN +: XLEN] = BYP ? nxt[ra[i]] : ((ZERO_REG != 0 && ra[i] == 0) ? '0 : m_reg[ra[i]]);
      for (int p = 0; p < NUM_WR; p++)
        if (we[p] && !(ZERO_REG != 0 && wa[p] == 0)) m_pend[wa[p]] = 0;
      if (ie) m_pend[ia] = 1;
      if (ZERO_REG != 0) m_pend[0] = 0;
      for (int a = 0; a < DEPTH; a++) m_reg[a] = nxt[a];
      for (int i = 0; i < NUM_RD; i++) e.pend[i] = m_pend[ra[i]];
    end
    @(posedge clk);
    q_exp.push_back(e);
    q_name.push_back(nm);
  endtask

  // Monitor: outputs are registered, so every edge presents one response.
  always @(negedge clk) begin
    if (q_exp.size() > 0) begin
      exp_t e;
      string nm;
      e = q_exp.pop_front();
      nm = q_name.pop_front();
      for (int i = 0; i < NUM_RD; i++) begin
        vectors++;
        if (rd_data[i*XLEN +: XLEN] !== e.data[i*XLEN +: XLEN] || rd_pending[i] !== e.pend[i]) begin
          miscompares++;
          $display("FAIL %s port%0d: got data=%h pend=%b, want data=%h pend=%b", nm, i,
                   rd_data[i*XLEN +: XLEN], rd_pending[i], e.data[i*XLEN +: XLEN], e.pend[i]);
        end
      end
    end
  end

  initial begin
    logic [1:0] we;
    rst = 1'b1; wr_en = '0; wr_addr = '0; wr_data = '0; rd_addr = '0; iss_en = 1'b0; iss_addr = '0;
    for (int a = 0; a < DEPTH; a++) begin m_reg[a] = '0; m_pend[a] = 0; end

    cyc("reset_state", 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("reset_state2", 1, 2'b00, 0, 0, 0, 0, 5, 9, 0, 0);
    // Reset loses both the earlier write and the one issued during reset
    cyc("pre_reset_wr", 0, 2'b01, 5, 32'hDEADBEEF, 0, 0, 5, 5, 1, 5);
    cyc("reset_cycle", 1, 2'b01, 5, 32'h11111111, 0, 0, 5, 5, 1, 5);
    cyc("after_reset", 0, 2'b00, 0, 0, 0, 0, 5, 5, 0, 0);
    // Zero register
    cyc("zero_wr_iss", 0, 2'b01, 0, 32'h1234, 0, 0, 0, 0, 1, 0);
    cyc("zero_rd", 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    // Write priority
    cyc("prio_wr", 0, 2'b11, 7, 32'hAAAA, 7, 32'h5555, 7, 1, 0, 0);
    cyc("prio_rd", 0, 2'b00, 0, 0, 0, 0, 7, 7, 0, 0);
    cyc("prio_rev", 0, 2'b11, 8, 32'h1, 8, 32'h2, 8, 8, 0, 0);
    cyc("prio_rev_rd", 0, 2'b00, 0, 0, 0, 0, 8, 8, 0, 0);
    // Bypass
    cyc("byp_seed", 0, 2'b01, 3, 32'h0BAD0BAD, 0, 0, 0, 0, 0, 0);
    cyc("byp_same", 0, 2'b10, 0, 0, 3, 32'hCAFEF00D, 3, 3, 0, 0);
    cyc("byp_next", 0, 2'b00, 0, 0, 0, 0, 3, 3, 0, 0);
    // Scoreboard
    cyc("sb_iss", 0, 2'b00, 0, 0, 0, 0, 9, 4, 1, 9);
    cyc("sb_rd", 0, 2'b00, 0, 0, 0, 0, 9, 9, 0, 0);
    cyc("sb_clr", 0, 2'b01, 9, 32'h99, 0, 0, 9, 9, 0, 0);
    cyc("sb_set_clr", 0, 2'b10, 0, 0, 9, 32'h77, 9, 9, 1, 9);
    cyc("sb_rd2", 0, 2'b00, 0, 0, 0, 0, 9, 9, 0, 0);

    for (int n = 0; n < 10000; n++) begin
      logic [AW-1:0] a [6];
      bit narrow;
      narrow = ($urandom_range(0, 1) == 1);
      for (int k = 0; k < 6; k++) a[k] = narrow ? AW'($urandom_range(0, 3)) : AW'($urandom);
      we = 2'($urandom);
      cyc("random", ($urandom_range(0, 199) == 0), we, a[0], $urandom, a[1], $urandom,
          a[2], a[3], ($urandom_range(0, 2) == 0), a[4]);
    end

    repeat (4) @(negedge clk);
    if (q_exp.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d responses outstanding, want 0", q_exp.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
